decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 36 +++
 rtl/decode_stage_register_file.sv | 53 +++++
 rtl/decode_stage.sv | 75 +++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Purpose: shared widths, register-file geometry and instruction field positions for the decode stage.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam int WORD_W     = 22;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int PC_REG     = 15;

    // Instruction field bit positions
    localparam int OP_HI        = 21;
    localparam int OP_LO        = 20;
    localparam int FUNCT_HI     = 19;
    localparam int FUNCT_LO     = 15;
    localparam int IMM_FLAG_BIT = 15;
    localparam int RN_HI        = 14;
    localparam int RN_LO        = 11;
    localparam int RD_HI        = 10;
    localparam int RD_LO        = 7;
    localparam int RM_HI        = 3;
    localparam int RM_LO        = 0;
    localparam int IMM_HI       = 6;
    localparam int IMM_LO       = 0;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t PC_ADDR = reg_addr_t'(PC_REG);

    // Zero-extend the 7-bit immediate field to a full word
    function automatic word_t zext_imm(input logic [IMM_HI-IMM_LO:0] imm);
        return word_t'(imm);
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// Purpose: 16 x 22-bit register file, two combinational read ports, one write port, R15 aliased to PC+8.
// Latency: reads 0 cycles (same-cycle write bypass), writes land at the rising edge.
// Backpressure: none; writes are never held off by pipeline stall or flush.
module register_file
    import decode_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  word_t     pc_plus_8,
    output word_t     rd1,
    output word_t     rd2
);

    word_t r_regs [NUM_REGS];
    word_t w_rd1;
    word_t w_rd2;

    // Reset clears every entry; R15 is never written since reads of it return PC+8
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != PC_ADDR)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Read ports: PC alias first, then same-cycle bypass of the writeback value, then array
    always_comb begin
        w_rd1 = r_regs[ra1];
        w_rd2 = r_regs[ra2];
        if (ra1 == PC_ADDR) begin
            w_rd1 = pc_plus_8;
        end else if (we && (waddr == ra1)) begin
            w_rd1 = wdata;
        end
        if (ra2 == PC_ADDR) begin
            w_rd2 = pc_plus_8;
        end else if (we && (waddr == ra2)) begin
            w_rd2 = wdata;
        end
    end

    assign rd1 = w_rd1;
    assign rd2 = w_rd2;

endmodule

// File: rtl/decode_stage.sv
// Purpose: IF/ID pipeline register plus instruction field decode and register-file operand read.
// Latency: fields and operands valid 1 cycle after fetch presents the instruction.
// Backpressure: stall_d holds IF/ID contents, flush_d replaces them with a bubble (flush wins).
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     instruction_fetch_in,
    input  logic [WORD_W-1:0]     pc_plus_8_in,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] write_addr_w,
    input  logic [WORD_W-1:0]     result_w,
    output logic                  valid_d,
    output logic [1:0]            op_d,
    output logic [4:0]            funct_d,
    output logic [REG_ADDR_W-1:0] rn_addr_d,
    output logic [REG_ADDR_W-1:0] rd_addr_d,
    output logic [REG_ADDR_W-1:0] rm_addr_d,
    output logic [WORD_W-1:0]     rd1_d,
    output logic [WORD_W-1:0]     rd2_d,
    output logic [WORD_W-1:0]     ext_imm_d,
    output logic [WORD_W-1:0]     pc_plus_8_d
);

    word_t     r_instr;
    word_t     r_pc;
    logic      r_valid;
    word_t     w_instr;
    reg_addr_t w_rn;
    reg_addr_t w_rm;

    // IF/ID register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!stall_d) begin
            r_instr <= instruction_fetch_in;
            r_pc    <= pc_plus_8_in;
            r_valid <= 1'b1;
        end
    end

    // A bubble already holds zero; the gate keeps decode zero even if that ever changes
    assign w_instr = r_valid ? r_instr : '0;
    assign w_rn    = w_instr[RN_HI:RN_LO];
    assign w_rm    = w_instr[RM_HI:RM_LO];

    assign valid_d     = r_valid;
    assign op_d        = w_instr[OP_HI:OP_LO];
    assign funct_d     = w_instr[FUNCT_HI:FUNCT_LO];
    assign rn_addr_d   = w_rn;
    assign rd_addr_d   = w_instr[RD_HI:RD_LO];
    assign rm_addr_d   = w_rm;
    assign ext_imm_d   = zext_imm(w_instr[IMM_HI:IMM_LO]);
    assign pc_plus_8_d = r_pc;

    register_file u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (reg_write_w),
        .waddr     (write_addr_w),
        .wdata     (result_w),
        .ra1       (w_rn),
        .ra2       (w_rm),
        .pc_plus_8 (r_pc),
        .rd1       (rd1_d),
        .rd2       (rd2_d)
    );

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] instruction_fetch_in;
    logic [21:0] pc_plus_8_in;
    logic        stall_d;
    logic        flush_d;
    logic        reg_write_w;
    logic [3:0]  write_addr_w;
    logic [21:0] result_w;
    logic        valid_d;
    logic [1:0]  op_d;
    logic [4:0]  funct_d;
    logic [3:0]  rn_addr_d;
    logic [3:0]  rd_addr_d;
    logic [3:0]  rm_addr_d;
    logic [21:0] rd1_d;
    logic [21:0] rd2_d;
    logic [21:0] ext_imm_d;
    logic [21:0] pc_plus_8_d;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_fetch_in (instruction_fetch_in),
        .pc_plus_8_in         (pc_plus_8_in),
        .stall_d              (stall_d),
        .flush_d              (flush_d),
        .reg_write_w          (reg_write_w),
        .write_addr_w         (write_addr_w),
        .result_w             (result_w),
        .valid_d              (valid_d),
        .op_d                 (op_d),
        .funct_d              (funct_d),
        .rn_addr_d            (rn_addr_d),
        .rd_addr_d            (rd_addr_d),
        .rm_addr_d            (rm_addr_d),
        .rd1_d                (rd1_d),
        .rd2_d                (rd2_d),
        .ext_imm_d            (ext_imm_d),
        .pc_plus_8_d          (pc_plus_8_d)
    );

    localparam int S_VALID = 0;
    localparam int S_OP    = 1;
    localparam int S_FUNCT = 2;
    localparam int S_RN    = 3;
    localparam int S_RD    = 4;
    localparam int S_RM    = 5;
    localparam int S_RD1   = 6;
    localparam int S_RD2   = 7;
    localparam int S_IMM   = 8;
    localparam int S_PC    = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [21:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    task automatic expect_val(input string name, input int sel, input logic [21:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    // Advance past the next rising edge; new inputs apply from here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so each cycle's expectations are checked mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [21:0] act;
            c = q.pop_front();
            case (c.sel)
                S_VALID: act = 22'(valid_d);
                S_OP:    act = 22'(op_d);
                S_FUNCT: act = 22'(funct_d);
                S_RN:    act = 22'(rn_addr_d);
                S_RD:    act = 22'(rd_addr_d);
                S_RM:    act = 22'(rm_addr_d);
                S_RD1:   act = rd1_d;
                S_RD2:   act = rd2_d;
                S_IMM:   act = ext_imm_d;
                S_PC:    act = pc_plus_8_d;
                default: act = 'x;
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%06h, expected 0x%06h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        rst                  = 1'b1;
        instruction_fetch_in = '0;
        pc_plus_8_in         = '0;
        stall_d              = 1'b0;
        flush_d              = 1'b0;
        reg_write_w          = 1'b0;
        write_addr_w         = '0;
        result_w             = '0;

        // Two reset edges
        tick();
        tick();
        rst                  = 1'b0;
        instruction_fetch_in = 22'h001800;   // Rn=3, Rm=0
        pc_plus_8_in         = 22'h000004;
        reg_write_w          = 1'b1;
        write_addr_w         = 4'd0;
        result_w             = 22'h00ABCD;
        expect_val("rst_valid", S_VALID, 22'h0);
        expect_val("rst_op",    S_OP,    22'h0);
        expect_val("rst_funct", S_FUNCT, 22'h0);
        expect_val("rst_rn",    S_RN,    22'h0);
        expect_val("rst_imm",   S_IMM,   22'h0);
        expect_val("rst_pc",    S_PC,    22'h0);
        expect_val("rst_bypass_rd1", S_RD1, 22'h00ABCD);
        expect_val("rst_bypass_rd2", S_RD2, 22'h00ABCD);

        // R0 now 0x0ABCD; first load Rn=3 visible
        tick();
        reg_write_w          = 1'b0;
        instruction_fetch_in = 22'h2A5C83;
        pc_plus_8_in         = 22'h000010;
        expect_val("load1_valid", S_VALID, 22'h1);
        expect_val("load1_rn",    S_RN,    22'h3);
        expect_val("r3_after_rst", S_RD1,  22'h0);
        expect_val("r0_written",  S_RD2,   22'h00ABCD);
        expect_val("load1_pc",    S_PC,    22'h000004);

        // Decode of 0x2A5C83
        tick();
        stall_d              = 1'b1;
        instruction_fetch_in = 22'h3FFFFF;
        pc_plus_8_in         = 22'h00003F;
        expect_val("dec_valid", S_VALID, 22'h1);
        expect_val("dec_op",    S_OP,    22'h2);
        expect_val("dec_funct", S_FUNCT, 22'h14);
        expect_val("dec_rn",    S_RN,    22'hB);
        expect_val("dec_rd",    S_RD,    22'h9);
        expect_val("dec_rm",    S_RM,    22'h3);
        expect_val("dec_imm",   S_IMM,   22'h3);
        expect_val("dec_pc",    S_PC,    22'h000010);
        expect_val("dec_rd1",   S_RD1,   22'h0);
        expect_val("dec_rd2",   S_RD2,   22'h0);

        // Three stall edges with changing fetch input
        tick();
        instruction_fetch_in = 22'h111111;
        pc_plus_8_in         = 22'h000022;
        expect_val("stall1_op",    S_OP,    22'h2);
        expect_val("stall1_funct", S_FUNCT, 22'h14);
        expect_val("stall1_pc",    S_PC,    22'h000010);
        tick();
        instruction_fetch_in = 22'h155555;
        expect_val("stall2_rn",  S_RN,  22'hB);
        expect_val("stall2_imm", S_IMM, 22'h3);
        tick();
        flush_d = 1'b1;
        expect_val("stall3_rd",    S_RD,    22'h9);
        expect_val("stall3_rm",    S_RM,    22'h3);
        expect_val("stall3_valid", S_VALID, 22'h1);

        // Flush beats stall
        tick();
        flush_d              = 1'b0;
        stall_d              = 1'b0;
        instruction_fetch_in = 22'h00200F;   // Rn=4, Rm=15
        pc_plus_8_in         = 22'h000020;
        expect_val("flush_valid", S_VALID, 22'h0);
        expect_val("flush_op",    S_OP,    22'h0);
        expect_val("flush_funct", S_FUNCT, 22'h0);
        expect_val("flush_rn",    S_RN,    22'h0);
        expect_val("flush_rm",    S_RM,    22'h0);
        expect_val("flush_imm",   S_IMM,   22'h0);
        expect_val("flush_pc",    S_PC,    22'h0);

        // Write R4 with same-cycle bypass; R15 read returns PC+8
        tick();
        stall_d      = 1'b1;
        reg_write_w  = 1'b1;
        write_addr_w = 4'd4;
        result_w     = 22'h012345;
        expect_val("bypass_r4",  S_RD1, 22'h012345);
        expect_val("r15_pc_a",   S_RD2, 22'h000020);

        tick();
        reg_write_w = 1'b0;
        result_w    = 22'h000000;
        expect_val("r4_persist", S_RD1, 22'h012345);

        // Write to R15 must neither bypass nor land
        tick();
        reg_write_w  = 1'b1;
        write_addr_w = 4'd15;
        result_w     = 22'h3FFFFF;
        expect_val("r15_no_bypass", S_RD2, 22'h000020);
        expect_val("r4_hold",       S_RD1, 22'h012345);

        tick();
        reg_write_w = 1'b0;
        expect_val("r15_after_wr", S_RD2, 22'h000020);

        // Reset with concurrent write to R2 and concurrent load
        tick();
        rst                  = 1'b1;
        stall_d              = 1'b0;
        reg_write_w          = 1'b1;
        write_addr_w         = 4'd2;
        result_w             = 22'h002222;
        instruction_fetch_in = 22'h001000;
        pc_plus_8_in         = 22'h000030;

        tick();
        rst                  = 1'b0;
        reg_write_w          = 1'b0;
        instruction_fetch_in = 22'h001004;   // Rn=2, Rm=4
        expect_val("rst2_valid", S_VALID, 22'h0);
        expect_val("rst2_pc",    S_PC,    22'h0);

        tick();
        expect_val("rst2_load_valid", S_VALID, 22'h1);
        expect_val("rst2_load_rn",    S_RN,    22'h2);
        expect_val("r2_cleared",      S_RD1,   22'h0);
        expect_val("r4_cleared",      S_RD2,   22'h0);

        stim_done = 1'b1;
    end

    // Termination: drain the scoreboard with a bounded wait
    initial begin
        int budget;
        budget = 2000;
        while (!stim_done && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (!stim_done || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: stim_done=%0d pending=%0d, expected stim_done=1 pending=0",
                     stim_done, q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
